// File: rtl/qpsk_modulator.sv
// QPSK carrier modulator: buffers {I,Q} dibits in a small FIFO and emits
// 8 signed carrier samples per symbol (out = I*cos + Q*sin, bit 1 -> +1,
// bit 0 -> -1). Back-to-back symbols stream with no gap in out_valid.
// Optional build macro QPSK_DIFF_ENC_EN enables per-channel differential
// encoding of each dibit as it is popped from the FIFO.
module qpsk_modulator #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    i_bit,
    input  logic                    q_bit,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [8:0]       out_sample,
    output logic                    out_valid,
    output logic                    sym_start,
    output logic [CNT_W-1:0]        sym_count,
    output logic [FIFO_AW:0]        fifo_level
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [1:0]           fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [2:0]           phase;
    logic [1:0]           sym_reg;
    logic [1:0]           pop_data, tx_dibit;
    logic signed [8:0]    cos_val, sin_val, sample_nxt;
    logic                 valid_nxt, start_nxt;

    function automatic logic signed [8:0] cos_lut(input logic [2:0] p);
        case (p)
            3'd0:    return 9'sd127;
            3'd1:    return 9'sd90;
            3'd2:    return 9'sd0;
            3'd3:    return -9'sd90;
            3'd4:    return -9'sd127;
            3'd5:    return -9'sd90;
            3'd6:    return 9'sd0;
            default: return 9'sd90;
        endcase
    endfunction

    function automatic logic signed [8:0] sin_lut(input logic [2:0] p);
        case (p)
            3'd0:    return 9'sd0;
            3'd1:    return 9'sd90;
            3'd2:    return 9'sd127;
            3'd3:    return 9'sd90;
            3'd4:    return 9'sd0;
            3'd5:    return -9'sd90;
            3'd6:    return -9'sd127;
            default: return -9'sd90;
        endcase
    endfunction

    assign full     = (fifo_level == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty    = (fifo_level == '0);
    assign in_ready = !full;
    // A pop in the same cycle does not free a slot for a push when full.
    assign push     = in_valid && !full;
    assign pop_data = fifo_mem[rd_ptr];

`ifdef QPSK_DIFF_ENC_EN
    logic [1:0] prev_tx;

    assign tx_dibit = pop_data ^ prev_tx;

    // Remember the last transmitted dibit for differential encoding.
    always_ff @(posedge clk1) begin
        if (rst)
            prev_tx <= 2'b00;
        else if (pop)
            prev_tx <= tx_dibit;
    end
`else
    assign tx_dibit = pop_data;
`endif

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and pop decision; the last phase pops the next dibit so
    // consecutive symbols run without a bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (state == IDLE) begin
            if (!empty) begin
                pop       = 1'b1;
                state_nxt = RUN;
            end
        end else if (phase == 3'd7) begin
            if (!empty)
                pop = 1'b1;
            else
                state_nxt = IDLE;
        end
    end

    // Output decode: carrier sample for the current phase while running.
    always_comb begin
        cos_val    = cos_lut(phase);
        sin_val    = sin_lut(phase);
        valid_nxt  = 1'b0;
        start_nxt  = 1'b0;
        sample_nxt = 9'sd0;
        if (state == RUN) begin
            valid_nxt  = 1'b1;
            start_nxt  = (phase == 3'd0);
            sample_nxt = (sym_reg[1] ? cos_val : -cos_val)
                       + (sym_reg[0] ? sin_val : -sin_val);
        end
    end

    // FIFO storage; contents need no reset because pointers gate access.
    always_ff @(posedge clk1) begin
        if (push)
            fifo_mem[wr_ptr] <= {i_bit, q_bit};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + {{FIFO_AW{1'b0}}, push}
                                     - {{FIFO_AW{1'b0}}, pop};
        end
    end

    // Symbol register and phase counter.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sym_reg <= 2'b00;
            phase   <= 3'd0;
        end else if (pop) begin
            sym_reg <= tx_dibit;
            phase   <= 3'd0;
        end else if (state == RUN) begin
            phase <= phase + 3'd1;
        end
    end

    // Registered outputs and symbol counter.
    always_ff @(posedge clk1) begin
        if (rst) begin
            out_sample <= 9'sd0;
            out_valid  <= 1'b0;
            sym_start  <= 1'b0;
            sym_count  <= '0;
        end else begin
            out_sample <= sample_nxt;
            out_valid  <= valid_nxt;
            sym_start  <= start_nxt;
            if (start_nxt)
                sym_count <= sym_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_qpsk_modulator.sv
// Self-checking bench for qpsk_modulator: table of dibits with hand-computed
// sample sequences, plus hand-written back-to-back, FIFO-full and
// mid-symbol reset sequences. Honours QPSK_DIFF_ENC_EN if defined.
module tb_qpsk_modulator;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              i_bit = 1'b0;
    logic              q_bit = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [8:0] out_sample;
    logic              out_valid;
    logic              sym_start;
    logic [15:0]       sym_count;
    logic [2:0]        fifo_level;

    qpsk_modulator #(.FIFO_DEPTH(4), .FIFO_AW(2), .CNT_W(16)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .i_bit      (i_bit),
        .q_bit      (q_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .sym_start  (sym_start),
        .sym_count  (sym_count),
        .fifo_level (fifo_level)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic i;
        logic q;
        int   exp [8];
    } vec_t;

    vec_t       vecs [4];
    logic [1:0] exp_q [$];
    logic [1:0] full_seq [7];
    int         model_cnt = 0;
    logic [1:0] prev_tx = 2'b00;
    int         errors = 0;
    int         checks = 0;
    logic       saw_full = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tx_peek(input logic [1:0] d);
`ifdef QPSK_DIFF_ENC_EN
        return d ^ prev_tx;
`else
        return d;
`endif
    endfunction

    function automatic logic [1:0] tx_apply(input logic [1:0] d);
        logic [1:0] t;
        t = tx_peek(d);
        prev_tx = t;
        return t;
    endfunction

    function automatic int row_of(input logic [1:0] t);
        int r;
        r = 0;
        for (int j = 0; j < 4; j++)
            if (vecs[j].i == t[1] && vecs[j].q == t[0]) r = j;
        return r;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk1);
        #1 rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        prev_tx = 2'b00;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sym_start", int'(sym_start), 0);
        check("rst_sym_count", int'(sym_count), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    // Called at #1 after an edge; presents one dibit for exactly one cycle.
    task automatic push_one(input logic i, input logic q);
        logic rdy;
        in_valid = 1'b1;
        i_bit = i;
        q_bit = q;
        rdy = in_ready;
        @(posedge clk1);
        if (rdy) exp_q.push_back({i, q});
        #1 in_valid = 1'b0;
    endtask

    // Waits for out_valid, then checks nsym contiguous symbols against the
    // model queue, then checks out_valid drops.
    task automatic collect(input int nsym, input int exp_wait);
        int w;
        int r;
        logic [1:0] d;
        w = 0;
        do begin
            @(posedge clk1);
            #1;
            w++;
        end while (!out_valid && w < 40);
        check("valid_arrival", int'(out_valid), 1);
        if (!out_valid) return;
        if (exp_wait > 0) check("first_sample_latency", w, exp_wait);
        for (int s = 0; s < nsym; s++) begin
            if (exp_q.size() == 0) begin
                check("model_queue_nonempty", 0, 1);
                return;
            end
            d = exp_q.pop_front();
            r = row_of(tx_apply(d));
            model_cnt++;
            for (int k = 0; k < 8; k++) begin
                if (s != 0 || k != 0) begin
                    @(posedge clk1);
                    #1;
                end
                check("out_valid", int'(out_valid), 1);
                check("out_sample", int'(out_sample), vecs[r].exp[k]);
                check("sym_start", int'(sym_start), (k == 0) ? 1 : 0);
                if (k == 0) check("sym_count", int'(sym_count), model_cnt & 16'hFFFF);
            end
        end
        @(posedge clk1);
        #1;
        check("valid_after_symbols", int'(out_valid), 0);
    endtask

    initial begin
        int vcount;
        int r;
        vecs[0].i = 1'b1; vecs[0].q = 1'b1;
        vecs[0].exp = '{127, 180, 127, 0, -127, -180, -127, 0};
        vecs[1].i = 1'b1; vecs[1].q = 1'b0;
        vecs[1].exp = '{127, 0, -127, -180, -127, 0, 127, 180};
        vecs[2].i = 1'b0; vecs[2].q = 1'b1;
        vecs[2].exp = '{-127, 0, 127, 180, 127, 0, -127, -180};
        vecs[3].i = 1'b0; vecs[3].q = 1'b0;
        vecs[3].exp = '{-127, -180, -127, 0, 127, 180, 127, 0};
        full_seq = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10};

        // Reset held 3 cycles
        do_reset(3);
        check_reset_outputs();

        // Single dibits into an idle block, one per table entry
        for (int v = 0; v < 4; v++) begin
            push_one(vecs[v].i, vecs[v].q);
            collect(1, 2);
        end

        // Back-to-back symbols: continuous 16 valid cycles
        push_one(1'b1, 1'b0);
        push_one(1'b0, 1'b1);
        collect(2, 1);

        // FIFO full with in_valid held while busy
        fork
            begin
                int n;
                int guard;
                logic rdy;
                n = 0;
                guard = 0;
                while (n < 7 && guard < 300) begin
                    in_valid = 1'b1;
                    i_bit = full_seq[n][1];
                    q_bit = full_seq[n][0];
                    rdy = in_ready;
                    if (fifo_level == 3'd4) begin
                        saw_full = 1'b1;
                        check("in_ready_when_full", int'(in_ready), 0);
                    end
                    @(posedge clk1);
                    if (rdy) begin
                        exp_q.push_back(full_seq[n]);
                        n++;
                    end
                    #1;
                    guard++;
                end
                in_valid = 1'b0;
                check("all_pushed", n, 7);
            end
            collect(7, 0);
        join
        check("fifo_reached_full", int'(saw_full), 1);
        check("fifo_drained", int'(fifo_level), 0);

        // Reset mid-symbol at phase 3 with two dibits queued
        push_one(1'b1, 1'b0);
        push_one(1'b0, 1'b0);
        push_one(1'b1, 1'b1);
        r = row_of(tx_peek(2'b10));
        repeat (3) @(posedge clk1);
        #1;
        check("pre_reset_valid", int'(out_valid), 1);
        check("pre_reset_phase3_sample", int'(out_sample), vecs[r].exp[3]);
        check("pre_reset_level", int'(fifo_level), 2);
        rst = 1'b1;
        @(posedge clk1);
        #1 rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        prev_tx = 2'b00;
        check_reset_outputs();
        vcount = 0;
        repeat (20) begin
            @(posedge clk1);
            #1;
            if (out_valid) vcount++;
        end
        check("no_stale_symbol", vcount, 0);

        // Post-reset operation is clean
        push_one(1'b0, 1'b1);
        collect(1, 2);

`ifdef QPSK_DIFF_ENC_EN
        // (1,1),(1,1) transmit as (1,1),(0,0): second symbol is the negation
        do_reset(2);
        push_one(1'b1, 1'b1);
        push_one(1'b1, 1'b1);
        collect(2, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
